// File: rtl/kf8255_handshake_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kf8255_handshake_port_pkg
// Description : Shared constants, port-mode enum and mode decoder for the
//               8255-style handshake port.
// Revision    : 1.0 - initial release
// ============================================================================
package kf8255_handshake_port_pkg;

    // Control-word mode field, matched with casez
    localparam logic [1:0] KF8255_CONTROL_MODE_0 = 2'b00;
    localparam logic [1:0] KF8255_CONTROL_MODE_1 = 2'b01;
    localparam logic [1:0] KF8255_CONTROL_MODE_2 = 2'b1?;

    // Pin direction encoding
    localparam logic PORT_INPUT  = 1'b1;
    localparam logic PORT_OUTPUT = 1'b0;

    typedef enum logic [1:0] {
        MODE0     = 2'd0,
        MODE1_IN  = 2'd1,
        MODE1_OUT = 2'd2,
        MODE2     = 2'd3
    } port_mode_t;

    // Collapse mode field and direction bit into a single operating mode
    function automatic port_mode_t decode_mode(input logic [1:0] sel, input logic dir);
        port_mode_t m;
        m = MODE0;
        casez (sel)
            KF8255_CONTROL_MODE_0: m = MODE0;
            KF8255_CONTROL_MODE_1: m = (dir == PORT_INPUT) ? MODE1_IN : MODE1_OUT;
            KF8255_CONTROL_MODE_2: m = MODE2;
            default:               m = MODE0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kf8255_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kf8255_sync_fifo
// Description : Small synchronous FIFO for strobed port input. Pushes while
//               full and pops while empty are ignored; clear empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8255_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH (a single-entry FIFO keeps pointer 0)
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Next pointer/level values from the accepted push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(negedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(negedge clock) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/kf8255_handshake_port.sv
`default_nettype none
// ============================================================================
// Module      : kf8255_handshake_port
// Description : 8255-style port with strobed input FIFO, mode-1/mode-2
//               handshake engine (IBF, OBF_N, INTR) and overrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8255_handshake_port
    import kf8255_handshake_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           internal_data_bus,
    input  logic                       write_port,
    input  logic                       read_port,
    input  logic                       update_mode,
    input  logic [1:0]                 mode_select_reg,
    input  logic                       port_io_reg,
    input  logic                       inte_in_reg,
    input  logic                       inte_out_reg,
    input  logic                       stb_n,
    input  logic                       ack_n,
    input  logic [WIDTH-1:0]           port_in,
    output logic [WIDTH-1:0]           port_out,
    output logic                       port_io,
    output logic [WIDTH-1:0]           read,
    output logic                       ibf,
    output logic                       obf_n,
    output logic                       intr,
    output logic                       overrun,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    port_mode_t       mode;
    logic             in_en, out_en;
    logic             stb_s1_q, stb_s2_q, stb_s3_q;
    logic             ack_s1_q, ack_s2_q, ack_s3_q;
    logic             stb_fall, stb_rise, ack_fall, ack_rise;
    logic             fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] fifo_head;
    logic [LVL_W-1:0] level_after;

    logic             port_io_q,  port_io_d;
    logic [WIDTH-1:0] port_out_q, port_out_d;
    logic [WIDTH-1:0] read_q,     read_d;
    logic             obf_n_q,    obf_n_d;
    logic             intr_in_q,  intr_in_d;
    logic             intr_out_q, intr_out_d;
    logic             overrun_q,  overrun_d;

    assign mode   = decode_mode(mode_select_reg, port_io_reg);
    assign in_en  = (mode == MODE1_IN)  || (mode == MODE2);
    assign out_en = (mode == MODE1_OUT) || (mode == MODE2);

    // Third flop of each chain holds the previous synchronized level
    assign stb_fall = stb_s3_q & ~stb_s2_q;
    assign stb_rise = ~stb_s3_q & stb_s2_q;
    assign ack_fall = ack_s3_q & ~ack_s2_q;
    assign ack_rise = ~ack_s3_q & ack_s2_q;

    assign fifo_clear  = ~reset | update_mode;
    assign fifo_push   = in_en & stb_fall;
    assign fifo_pop    = in_en & read_port;
    assign push_ok     = fifo_push & ~fifo_full;
    assign pop_ok      = fifo_pop & ~fifo_empty;
    assign level_after = fifo_level + LVL_W'(push_ok) - LVL_W'(pop_ok);

    kf8255_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (port_in),
        .head    (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Two-flop synchronizers plus edge-detect register for strobe and ack
    always_ff @(negedge clock) begin
        if (!reset) begin
            stb_s1_q <= 1'b1;
            stb_s2_q <= 1'b1;
            stb_s3_q <= 1'b1;
            ack_s1_q <= 1'b1;
            ack_s2_q <= 1'b1;
            ack_s3_q <= 1'b1;
        end else begin
            stb_s1_q <= stb_n;
            stb_s2_q <= stb_s1_q;
            stb_s3_q <= stb_s2_q;
            ack_s1_q <= ack_n;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    // Handshake engines, direction and read-data selection
    always_comb begin
        port_io_d  = port_io_q;
        port_out_d = port_out_q;
        read_d     = read_q;
        obf_n_d    = obf_n_q;
        intr_in_d  = intr_in_q;
        intr_out_d = intr_out_q;
        overrun_d  = overrun_q;

        if (mode == MODE2) begin
            port_io_d = ack_s2_q ? PORT_INPUT : PORT_OUTPUT;
        end else begin
            port_io_d = port_io_reg;
        end

        // Mode 0 output is a plain latch with no handshake
        if ((mode == MODE0) && (port_io_reg == PORT_OUTPUT) && write_port) begin
            port_out_d = internal_data_bus;
        end

        // Output engine: a CPU write beats any coincident ack edge
        if (out_en) begin
            if (write_port) begin
                port_out_d = internal_data_bus;
                obf_n_d    = 1'b0;
                intr_out_d = 1'b0;
            end else if (ack_fall) begin
                obf_n_d = 1'b1;
            end else if (ack_rise && obf_n_q && inte_out_reg) begin
                intr_out_d = 1'b1;
            end
        end

        // Input engine: overrun on a dropped strobe, intr tracks occupancy
        if (in_en) begin
            if (fifo_push && fifo_full) begin
                overrun_d = 1'b1;
            end
            if (pop_ok && (level_after == '0)) begin
                intr_in_d = 1'b0;
            end else if (stb_rise && inte_in_reg && (level_after != '0)) begin
                intr_in_d = 1'b1;
            end
        end

        case (mode)
            MODE0:     read_d = (port_io_reg == PORT_INPUT) ? port_in : port_out_d;
            MODE1_OUT: read_d = port_out_d;
            default:   read_d = fifo_empty ? '0 : fifo_head;
        endcase

        // Control-word write clears everything except direction
        if (update_mode) begin
            port_io_d  = port_io_q;
            port_out_d = '0;
            read_d     = '0;
            obf_n_d    = 1'b1;
            intr_in_d  = 1'b0;
            intr_out_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // Port state registers
    always_ff @(negedge clock) begin
        if (!reset) begin
            port_io_q  <= PORT_INPUT;
            port_out_q <= '0;
            read_q     <= '0;
            obf_n_q    <= 1'b1;
            intr_in_q  <= 1'b0;
            intr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            port_io_q  <= port_io_d;
            port_out_q <= port_out_d;
            read_q     <= read_d;
            obf_n_q    <= obf_n_d;
            intr_in_q  <= intr_in_d;
            intr_out_q <= intr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    assign port_io  = port_io_q;
    assign port_out = port_out_q;
    assign read     = read_q;
    assign ibf      = (fifo_level != '0);
    assign obf_n    = obf_n_q;
    assign intr     = intr_in_q | intr_out_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire
